// File: rtl/tc_pl_spi_pkg.sv
// Shared types and constants for the SPI master engine.
// Optional feature macro: TC_PL_SPI_LOOPBACK_EN (see tc_pl_spi_engine).
package tc_pl_spi_pkg;

    localparam int BYTE_W  = 8;
    localparam int EOF_BIT = 8;
    localparam int HALF_N  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_PUSH  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

endpackage

// File: rtl/tc_pl_spi_clkgen.sv
// SCLK half-period timer: CLK_DIV cycles per half, 16 halves per byte.
// Emits rise/fall strobes in the last cycle of each half-period.
module tc_pl_spi_clkgen
    import tc_pl_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       rise,
    output logic       fall,
    output logic [3:0] half_cnt
);

    logic [7:0] cnt_q, cnt_d;
    logic [3:0] hp_q, hp_d;
    logic       last;

    assign last     = (cnt_q == 8'(CLK_DIV - 1));
    assign rise     = run && last && !hp_q[0];
    assign fall     = run && last && hp_q[0];
    assign half_cnt = hp_q;

    always_comb begin
        cnt_d = cnt_q;
        hp_d  = hp_q;
        if (!run) begin
            cnt_d = '0;
            hp_d  = '0;
        end else if (last) begin
            cnt_d = '0;
            hp_d  = hp_q + 4'd1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            hp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hp_q  <= hp_d;
        end
    end

endmodule

// File: rtl/tc_pl_spi_engine.sv
// FIFO-fed SPI mode-0 master, MSB first, back-to-back frames on one CS.
// Define TC_PL_SPI_LOOPBACK_EN to sample MOSI internally instead of spi_miso.
module tc_pl_spi_engine
    import tc_pl_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              txb_empty,
    output logic              txbo_req,
    input  logic [EOF_BIT:0]  txbo_data,
    input  logic              rxb_full,
    output logic [BYTE_W-1:0] rxbi_data,
    output logic              rxbi_valid,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              busy,
    output logic              rx_ovf
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic              eof_q, eof_d;
    logic              cs_q, cs_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        gap_q, gap_d;

    logic       run;
    logic       rise;
    logic       fall;
    logic [3:0] half_cnt;
    logic       last_fall;
    logic       stop;
    logic       miso_s;

    tc_pl_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .rise     (rise),
        .fall     (fall),
        .half_cnt (half_cnt)
    );

`ifdef TC_PL_SPI_LOOPBACK_EN
    assign miso_s = spi_mosi;
`else
    assign miso_s = spi_miso;
`endif

    assign run       = (state_q == ST_SHIFT);
    assign last_fall = fall && (half_cnt == 4'(HALF_N - 1));
    assign stop      = eof_q || txb_empty || !en;

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        eof_d   = eof_q;
        cs_d    = cs_q;
        ovf_d   = ovf_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en && !txb_empty) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (txb_empty) begin
                    state_d = ST_GAP;
                    cs_d    = 1'b0;
                    gap_d   = '0;
                end else begin
                    state_d = ST_LOAD;
                    cs_d    = 1'b1;
                end
            end
            ST_LOAD: begin
                tx_d    = txbo_data[BYTE_W-1:0];
                eof_d   = txbo_data[EOF_BIT];
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (rise) rx_d = {rx_q[BYTE_W-2:0], miso_s};
                if (fall && !last_fall) tx_d = {tx_q[BYTE_W-2:0], 1'b0};
                if (last_fall) state_d = ST_PUSH;
            end
            ST_PUSH: begin
                if (rxb_full) ovf_d = 1'b1;
                if (stop) begin
                    state_d = ST_GAP;
                    cs_d    = 1'b0;
                    gap_d   = '0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == 8'(CS_GAP - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            eof_q   <= 1'b0;
            cs_q    <= 1'b0;
            ovf_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            eof_q   <= eof_d;
            cs_q    <= cs_d;
            ovf_q   <= ovf_d;
            gap_q   <= gap_d;
        end
    end

    // CS drops already in the PUSH cycle when no further byte follows
    assign spi_cs_n   = !cs_q || ((state_q == ST_PUSH) && stop);
    assign txbo_req   = (state_q == ST_REQ) && !txb_empty;
    assign rxbi_valid = (state_q == ST_PUSH) && !rxb_full;
    assign rxbi_data  = rx_q;
    assign spi_sclk   = run && half_cnt[0];
    assign busy       = (state_q != ST_IDLE);
    assign rx_ovf     = ovf_q;

    always_comb begin
        spi_mosi = 1'b0;
        if (state_q == ST_LOAD) spi_mosi = txbo_data[BYTE_W-1];
        else if (run)           spi_mosi = tx_q[BYTE_W-1];
    end

endmodule

// File: tb/tb_tc_pl_spi_engine.sv
// Directed bench for tc_pl_spi_engine with a small FIFO model.
// Define TC_PL_SPI_LOOPBACK_EN for the loopback variant.
module tb_tc_pl_spi_engine;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 2;

    logic       clk;
    logic       rst;
    logic       en;
    logic       txb_empty;
    logic       txbo_req;
    logic [8:0] txbo_data;
    logic       rxb_full;
    logic [7:0] rxbi_data;
    logic       rxbi_valid;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       busy;
    logic       rx_ovf;

    tc_pl_spi_engine #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .txb_empty  (txb_empty),
        .txbo_req   (txbo_req),
        .txbo_data  (txbo_data),
        .rxb_full   (rxb_full),
        .rxbi_data  (rxbi_data),
        .rxbi_valid (rxbi_valid),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .busy       (busy),
        .rx_ovf     (rx_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] fifo[$];

    int          n_req, n_valid, n_rise, n_cs_fall;
    int          cs_low, n_gap, req_empty;
    logic [15:0] mosi_bits;
    logic [7:0]  last_rx;
    logic        sclk_prev, cs_prev, seen_busy;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_req     = 0;
        n_valid   = 0;
        n_rise    = 0;
        n_cs_fall = 0;
        cs_low    = 0;
        n_gap     = 0;
        mosi_bits = '0;
        last_rx   = '0;
        seen_busy = 1'b0;
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
    endtask

    task automatic push(input logic [8:0] w);
        fifo.push_back(w);
        txb_empty = 1'b0;
    endtask

    // One clk cycle: FIFO pops on the edge after a read strobe
    task automatic step();
        logic req_prev;
        req_prev = txbo_req;
        @(posedge clk);
        #1;
        if (req_prev && fifo.size() > 0) txbo_data = fifo.pop_front();
        txb_empty = (fifo.size() == 0);
        #1;
        if (txbo_req) n_req++;
        if (txbo_req && txb_empty) req_empty++;
        if (rxbi_valid) begin
            n_valid++;
            last_rx = rxbi_data;
        end
        if (spi_sclk && !sclk_prev) begin
            n_rise++;
            mosi_bits = {mosi_bits[14:0], spi_mosi};
        end
        if (!spi_cs_n) cs_low++;
        if (!spi_cs_n && cs_prev) n_cs_fall++;
        if (busy && spi_cs_n && !txbo_req) n_gap++;
        if (busy) seen_busy = 1'b1;
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (!(seen_busy && !busy) && n < max) begin
            step();
            n++;
        end
        check({tag, "_busy_seen"}, 32'(seen_busy), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        txb_empty = 1'b1;
        txbo_data = '0;
        rxb_full  = 1'b0;
        spi_miso  = 1'b0;
        req_empty = 0;
        clear_mon();
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_req",   32'(txbo_req),   32'd0);
        check("rst_valid", 32'(rxbi_valid), 32'd0);
        check("rst_data",  32'(rxbi_data),  32'd0);
        check("rst_sclk",  32'(spi_sclk),   32'd0);
        check("rst_mosi",  32'(spi_mosi),   32'd0);
        check("rst_cs_n",  32'(spi_cs_n),   32'd1);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_ovf",   32'(rx_ovf),     32'd0);

        // Single EOF byte 0xA5, MISO high
        en       = 1'b1;
        spi_miso = 1'b1;
        clear_mon();
        push(9'h1A5);
        wait_idle("f1", 300);
        check("f1_req",    32'(n_req),          32'd1);
        check("f1_rise",   32'(n_rise),         32'd8);
        check("f1_mosi",   32'(mosi_bits[7:0]), 32'hA5);
        check("f1_valid",  32'(n_valid),        32'd1);
        check("f1_rx",     32'(last_rx),        32'hFF);
        check("f1_cs_low", 32'(cs_low),         32'd65);
        check("f1_gap",    32'(n_gap),          32'(CS_GAP + 1));

        // Back-to-back pair 0x3C then 0xC3 (EOF), MISO low
        spi_miso = 1'b0;
        clear_mon();
        push(9'h03C);
        push(9'h1C3);
        wait_idle("f2", 400);
        check("f2_req",     32'(n_req),     32'd2);
        check("f2_valid",   32'(n_valid),   32'd2);
        check("f2_cs_fall", 32'(n_cs_fall), 32'd1);
        check("f2_cs_low",  32'(cs_low),    32'd132);
        check("f2_mosi",    32'(mosi_bits), 32'h3CC3);
        check("f2_rx",      32'(last_rx),   32'h00);
        check("f2_gap",     32'(n_gap),     32'(CS_GAP + 1));

        // RX FIFO full at PUSH of 0x55 -> drop and sticky overflow
        rxb_full = 1'b1;
        clear_mon();
        push(9'h155);
        wait_idle("ovf", 300);
        check("ovf_valid", 32'(n_valid), 32'd0);
        check("ovf_flag",  32'(rx_ovf),  32'd1);
        rxb_full = 1'b0;
        spi_miso = 1'b1;
        clear_mon();
        push(9'h1FF);
        wait_idle("ovf2", 300);
        check("ovf2_valid", 32'(n_valid), 32'd1);
        check("ovf2_flag",  32'(rx_ovf),  32'd1);

        // Reset at half-period 7 of a byte
        clear_mon();
        push(9'h1AA);
        begin
            int n;
            n = 0;
            while (n_rise < 4 && n < 100) begin
                step();
                n++;
            end
        end
        check("mid_rise", 32'(n_rise), 32'd4);
        rst = 1'b1;
        step();
        check("mid_cs_n",  32'(spi_cs_n),  32'd1);
        check("mid_sclk",  32'(spi_sclk),  32'd0);
        check("mid_busy",  32'(busy),      32'd0);
        check("mid_ovf",   32'(rx_ovf),    32'd0);
        check("mid_data",  32'(rxbi_data), 32'd0);
        rst = 1'b0;
        repeat (80) step();
        check("mid_valid", 32'(n_valid), 32'd0);

        // en low holds off requests; en high starts at once
        en = 1'b0;
        clear_mon();
        push(9'h066);
        push(9'h099);
        repeat (8) step();
        check("en0_req",  32'(n_req), 32'd0);
        check("en0_busy", 32'(busy),  32'd0);
        en = 1'b1;
        step();
        check("en1_req", 32'(txbo_req), 32'd1);
        repeat (4) step();
        // en drops mid-byte: byte completes, then frame ends
        en = 1'b0;
        wait_idle("enf", 300);
        check("enf_req",   32'(n_req),          32'd1);
        check("enf_valid", 32'(n_valid),        32'd1);
        check("enf_rx",    32'(last_rx),        32'hFF);
        check("enf_mosi",  32'(mosi_bits[7:0]), 32'h66);
        check("enf_gap",   32'(n_gap),          32'(CS_GAP + 1));
        fifo.delete();
        txb_empty = 1'b1;
        en        = 1'b1;
        step();

        spi_miso = 1'b0;
        clear_mon();
        push(9'h15A);
        wait_idle("lb", 300);
`ifdef TC_PL_SPI_LOOPBACK_EN
        check("lb_rx", 32'(last_rx), 32'h5A);
`else
        check("lb_rx", 32'(last_rx), 32'h00);
`endif
        check("lb_valid", 32'(n_valid), 32'd1);

        check("req_while_empty", 32'(req_empty), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
